dmem_arbiter: RTL



---
 rtl/dmem_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-port data memory.
// Each granted access runs IDLE -> ACCESS -> DONE and returns a one-cycle ack (and err if out of range).
module dmem_arbiter #(
    parameter int unsigned RAM_SIZE   = 256,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic        ack0,
    output logic        err0,
    output logic [31:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic        ack1,
    output logic        err1,
    output logic [31:0] rdata1,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_next;
    logic        last_win;
    logic        err_flag;
    logic        grant;
    logic        win;
    logic        win_we;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic        win_oor;

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        win        = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    grant      = 1'b1;
                    // On a tie the port that did not win last time goes first
                    if (req0 & req1) win = FIXED_PRIO ? 1'b0 : ~last_win;
                    else             win = req1;
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign win_we    = win ? we1 : we0;
    assign win_addr  = win ? addr1 : addr0;
    assign win_wdata = win ? wdata1 : wdata0;
    assign win_oor   = win_addr >= 32'(RAM_SIZE);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner     <= 1'b0;
            last_win  <= 1'b1;
            err_flag  <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err0 <= 1'b0;
            err1 <= 1'b0;
            if (grant) begin
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
                owner     <= win;
                last_win  <= win;
                err_flag  <= win_oor;
                mem_rd    <= ~win_we & ~win_oor;
                mem_wr    <= win_we & ~win_oor;
            end
            if (state == ACCESS) begin
                mem_rd <= 1'b0;
                mem_wr <= 1'b0;
                if (owner) begin
                    ack1 <= 1'b1;
                    err1 <= err_flag;
                    if (err_flag)    rdata1 <= '0;
                    else if (mem_rd) rdata1 <= mem_rdata;
                end else begin
                    ack0 <= 1'b1;
                    err0 <= err_flag;
                    if (err_flag)    rdata0 <= '0;
                    else if (mem_rd) rdata0 <= mem_rdata;
                end
            end
        end
    end

endmodule
